odd_pipe_dispatch: RTL and testbench

Issue-side initiator for the odd pipe; the producer that drives the odd pipe's opcode, operand, immediate and PC inputs.
- Buffers decoded odd-pipe instructions in a small in-order FIFO.
- Reads source operands from the register file.
- Holds back any instruction with a RAW/WAW hazard against in-flight odd-pipe results, using a 7-stage scoreboard that mirrors fw_op_st_1..7.
- Issues at most one instruction per cycle; issues LNOP otherwise.

---
 rtl/odd_pipe_dispatch_pkg.sv | 65 ++++++
 rtl/odd_issue_fifo.sv | 52 +++++
 rtl/odd_pipe_dispatch.sv | 126 ++++++++++++
 tb/tb_odd_pipe_dispatch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_pipe_dispatch_pkg.sv
// Shared types for odd-pipe dispatch: opcodes, queued-instruction and scoreboard records, latency table.
// No logic of its own; latency and backpressure are properties of the modules that import it.
// Immediate slice widths follow the odd pipe's I7/I10/I16/I18 operand fields.
package odd_pipe_dispatch_pkg;

    typedef enum logic [4:0] {
        LNOP,
        SHIFT_LEFT_QUADWORD_BY_BITS,
        SHIFT_LEFT_QUADWORD_BY_BYTES,
        ROTATE_QUADWORD_BY_BITS,
        ROTATE_QUADWORD_BY_BYTES,
        ROTATE_QUADWORD_BY_BYTES_IMMEDIATE,
        GATHER_BITS_FROM_BYTES,
        LOAD_QUADWORD_DFORM,
        LOAD_QUADWORD_AFORM,
        STORE_QUADWORD_DFORM,
        STORE_QUADWORD_AFORM,
        BRANCH_RELATIVE,
        BRANCH_INDIRECT
    } opcode_t;

    localparam int REG_W  = 7;
    localparam int IMM_W  = 18;
    localparam int PC_W   = 32;
    localparam int DATA_W = 128;
    localparam int LAT_W  = 3;
    localparam int I7_W   = 7;
    localparam int I10_W  = 10;
    localparam int I16_W  = 16;

    typedef struct packed {
        opcode_t            op;
        logic [REG_W-1:0]   ra_addr;
        logic [REG_W-1:0]   rb_addr;
        logic               ra_used;
        logic               rb_used;
        logic [REG_W-1:0]   rt_addr;
        logic               rt_wr;
        logic [IMM_W-1:0]   imm;
        logic [PC_W-1:0]    pc;
    } instr_t;

    typedef struct packed {
        logic               vld;
        logic [REG_W-1:0]   rt;
        logic [LAT_W-1:0]   lat;
    } sb_entry_t;

    function automatic logic [LAT_W-1:0] op_latency(input opcode_t op);
        case (op)
            SHIFT_LEFT_QUADWORD_BY_BITS,
            SHIFT_LEFT_QUADWORD_BY_BYTES,
            ROTATE_QUADWORD_BY_BITS,
            ROTATE_QUADWORD_BY_BYTES,
            ROTATE_QUADWORD_BY_BYTES_IMMEDIATE,
            GATHER_BITS_FROM_BYTES:             return LAT_W'(4);
            LOAD_QUADWORD_DFORM,
            LOAD_QUADWORD_AFORM,
            STORE_QUADWORD_DFORM,
            STORE_QUADWORD_AFORM:               return LAT_W'(6);
            default:                            return LAT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/odd_issue_fifo.sv
// In-order instruction queue of DEPTH entries with synchronous flush.
// Latency: written at the clock edge, visible at the head the following cycle.
// Backpressure: full blocks push unless a pop happens in the same cycle.
module odd_issue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic push_vld,
    input  T     push_dat,
    input  logic pop_rdy,
    output T     head_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // The extra pointer bit separates full from empty; wrap is the natural overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/odd_pipe_dispatch.sv
// Odd-pipe issue stage: queues decoded instructions, reads operands, blocks RAW/WAW hazards.
// Latency: issue decided combinationally on the queue head, presented on registered outputs next cycle.
// Backpressure: in_ready drops when the queue is full or a flush is active; hazards hold the head.
module odd_pipe_dispatch
    import odd_pipe_dispatch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SB_STAGES = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  opcode_t             in_op_code,
    input  logic [REG_W-1:0]    in_ra_addr,
    input  logic [REG_W-1:0]    in_rb_addr,
    input  logic                in_ra_used,
    input  logic                in_rb_used,
    input  logic [REG_W-1:0]    in_rt_addr,
    input  logic                in_rt_wr,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic [REG_W-1:0]    rf_ra_addr,
    output logic [REG_W-1:0]    rf_rb_addr,
    input  logic [DATA_W-1:0]   rf_ra_data,
    input  logic [DATA_W-1:0]   rf_rb_data,
    output opcode_t             op_op_code,
    output logic [DATA_W-1:0]   ra,
    output logic [DATA_W-1:0]   rb,
    output logic [REG_W-1:0]    rt_address,
    output logic [I7_W-1:0]     I7,
    output logic [I10_W-1:0]    I10,
    output logic [I16_W-1:0]    I16,
    output logic [IMM_W-1:0]    I18,
    output logic [PC_W-1:0]     pc_output,
    output logic                issue_valid,
    output logic                stall
);

    instr_t     in_dat;
    instr_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       hazard;
    logic       issue;
    sb_entry_t  sb_q [SB_STAGES];

    assign in_ready = !fifo_full && !flush;
    assign in_dat   = '{op: in_op_code, ra_addr: in_ra_addr, rb_addr: in_rb_addr,
                        ra_used: in_ra_used, rb_used: in_rb_used, rt_addr: in_rt_addr,
                        rt_wr: in_rt_wr, imm: in_imm, pc: in_pc};

    odd_issue_fifo #(.DEPTH(DEPTH), .T(instr_t)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push_vld (in_valid && in_ready),
        .push_dat (in_dat),
        .pop_rdy  (issue),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rf_ra_addr = head.ra_addr;
    assign rf_rb_addr = head.rb_addr;

    // Stage s (index s-1) is s cycles old; its result is pending while s <= lat.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < SB_STAGES; s++) begin
            if (sb_q[s].vld && (s + 1) <= int'(sb_q[s].lat) &&
                ((head.ra_used && sb_q[s].rt == head.ra_addr) ||
                 (head.rb_used && sb_q[s].rt == head.rb_addr) ||
                 (head.rt_wr   && sb_q[s].rt == head.rt_addr)))
                hazard = 1'b1;
        end
    end

    assign issue = !fifo_empty && !hazard && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_op_code  <= LNOP;
            ra          <= '0;
            rb          <= '0;
            rt_address  <= '0;
            I7          <= '0;
            I10         <= '0;
            I16         <= '0;
            I18         <= '0;
            pc_output   <= '0;
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            for (int s = 0; s < SB_STAGES; s++) sb_q[s] <= '0;
        end else begin
            issue_valid <= issue;
            stall       <= !fifo_empty && hazard && !flush;
            if (issue) begin
                op_op_code <= head.op;
                ra         <= rf_ra_data;
                rb         <= rf_rb_data;
                rt_address <= head.rt_addr;
                I7         <= head.imm[I7_W-1:0];
                I10        <= head.imm[I10_W-1:0];
                I16        <= head.imm[I16_W-1:0];
                I18        <= head.imm;
                pc_output  <= head.pc;
            end else begin
                op_op_code <= LNOP;
                ra         <= '0;
                rb         <= '0;
                rt_address <= '0;
                I7         <= '0;
                I10        <= '0;
                I16        <= '0;
                I18        <= '0;
                pc_output  <= '0;
            end
            sb_q[0] <= '{vld: issue && head.rt_wr, rt: head.rt_addr, lat: op_latency(head.op)};
            for (int s = 1; s < SB_STAGES; s++) sb_q[s] <= sb_q[s-1];
        end
    end

endmodule

// File: tb/tb_odd_pipe_dispatch.sv
// Bench for odd_pipe_dispatch: directed scenarios plus random traffic against a queue-based model.
module tb_odd_pipe_dispatch;
    import odd_pipe_dispatch_pkg::*;

    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    opcode_t       in_op_code = LNOP;
    logic [6:0]    in_ra_addr = '0, in_rb_addr = '0, in_rt_addr = '0;
    logic          in_ra_used = 1'b0, in_rb_used = 1'b0, in_rt_wr = 1'b0;
    logic [17:0]   in_imm = '0;
    logic [31:0]   in_pc = '0;
    logic          flush = 1'b0;
    logic [6:0]    rf_ra_addr, rf_rb_addr;
    logic [127:0]  rf_ra_data, rf_rb_data;
    opcode_t       op_op_code;
    logic [127:0]  ra, rb;
    logic [6:0]    rt_address;
    logic [6:0]    I7;
    logic [9:0]    I10;
    logic [15:0]   I16;
    logic [17:0]   I18;
    logic [31:0]   pc_output;
    logic          issue_valid, stall;

    odd_pipe_dispatch #(.DEPTH(DEPTH), .SB_STAGES(7)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rt_addr(in_rt_addr),
        .in_rt_wr(in_rt_wr), .in_imm(in_imm), .in_pc(in_pc), .flush(flush),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .op_op_code(op_op_code), .ra(ra), .rb(rb), .rt_address(rt_address),
        .I7(I7), .I10(I10), .I16(I16), .I18(I18), .pc_output(pc_output),
        .issue_valid(issue_valid), .stall(stall)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] rf_val(input logic [6:0] a);
        return {4{32'hC0DE_0000 ^ (32'(a) * 32'h0001_0203)}};
    endfunction

    assign rf_ra_data = rf_val(rf_ra_addr);
    assign rf_rb_data = ~rf_val(rf_rb_addr);

    typedef struct {
        opcode_t     op;
        logic [6:0]  ra, rb, rt;
        bit          ra_u, rb_u, rt_w;
        logic [17:0] imm;
        logic [31:0] pc;
    } tinst_t;

    typedef struct {
        logic [6:0] rt;
        int         lat;
        int         cyc;
    } flight_t;

    tinst_t   mq[$];
    flight_t  inflight[$];
    int       cyc = 0;
    int       checks = 0, failures = 0;
    int       iss_cyc[32];
    int       stall_cnt = 0, n_iss = 0;
    bit       last_rdy;

    opcode_t  ops[12] = '{SHIFT_LEFT_QUADWORD_BY_BITS, SHIFT_LEFT_QUADWORD_BY_BYTES,
                          ROTATE_QUADWORD_BY_BITS, ROTATE_QUADWORD_BY_BYTES,
                          ROTATE_QUADWORD_BY_BYTES_IMMEDIATE, GATHER_BITS_FROM_BYTES,
                          LOAD_QUADWORD_DFORM, LOAD_QUADWORD_AFORM, STORE_QUADWORD_DFORM,
                          STORE_QUADWORD_AFORM, BRANCH_RELATIVE, BRANCH_INDIRECT};

    function automatic int lat_of(input opcode_t op);
        case (op)
            LOAD_QUADWORD_DFORM, LOAD_QUADWORD_AFORM,
            STORE_QUADWORD_DFORM, STORE_QUADWORD_AFORM: return 6;
            BRANCH_RELATIVE, BRANCH_INDIRECT:           return 1;
            default:                                    return 4;
        endcase
    endfunction

    function automatic bit writes_rt(input opcode_t op);
        return !(op inside {STORE_QUADWORD_DFORM, STORE_QUADWORD_AFORM,
                            BRANCH_RELATIVE, BRANCH_INDIRECT});
    endfunction

    function automatic tinst_t mk(input opcode_t op, input int a, input int b, input bit au,
                                  input bit bu, input int t, input int imm, input int pc);
        tinst_t i;
        i.op = op; i.ra = 7'(a); i.rb = 7'(b); i.ra_u = au; i.rb_u = bu;
        i.rt = 7'(t); i.rt_w = writes_rt(op); i.imm = 18'(imm); i.pc = 32'(pc);
        return i;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, predict from the model, check registered outputs next negedge.
    task automatic step(input bit v, input tinst_t i, input bit fl, output bit acc);
        bit rdy, hz, iss;
        tinst_t h;
        opcode_t e_op;
        logic [127:0] e_ra, e_rb;
        logic [6:0] e_rt;
        logic [17:0] e_imm;
        logic [31:0] e_pc;
        bit e_stall;
        in_valid = v; in_op_code = i.op; in_ra_addr = i.ra; in_rb_addr = i.rb;
        in_ra_used = i.ra_u; in_rb_used = i.rb_u; in_rt_addr = i.rt; in_rt_wr = i.rt_w;
        in_imm = i.imm; in_pc = i.pc; flush = fl;
        #1;
        rdy = (mq.size() < DEPTH) && !fl;
        last_rdy = in_ready;
        chk("in_ready", in_ready, rdy);
        hz = 0;
        h = i;
        if (mq.size() > 0) begin
            h = mq[0];
            chk("rf_ra_addr", rf_ra_addr, h.ra);
            chk("rf_rb_addr", rf_rb_addr, h.rb);
            foreach (inflight[k]) begin
                int age;
                age = cyc - inflight[k].cyc;
                if (age >= 1 && age <= inflight[k].lat &&
                    ((h.ra_u && inflight[k].rt == h.ra) || (h.rb_u && inflight[k].rt == h.rb) ||
                     (h.rt_w && inflight[k].rt == h.rt)))
                    hz = 1;
            end
        end
        iss = (mq.size() > 0) && !hz && !fl;
        e_stall = (mq.size() > 0) && hz && !fl;
        acc = v && rdy;
        e_op = LNOP; e_ra = '0; e_rb = '0; e_rt = '0; e_imm = '0; e_pc = '0;
        if (iss) begin
            e_op = h.op; e_ra = rf_val(h.ra); e_rb = ~rf_val(h.rb);
            e_rt = h.rt; e_imm = h.imm; e_pc = h.pc;
            if (h.rt_w) inflight.push_back('{h.rt, lat_of(h.op), cyc});
        end
        if (fl) mq.delete();
        else if (iss) void'(mq.pop_front());
        if (acc) mq.push_back(i);
        while (inflight.size() > 0 && cyc - inflight[0].cyc > 8) void'(inflight.pop_front());
        cyc++;
        @(posedge clock);
        @(negedge clock);
        chk("op_op_code", op_op_code, e_op);
        chk("issue_valid", issue_valid, iss);
        chk("stall", stall, e_stall);
        chk("ra", ra, e_ra);
        chk("rb", rb, e_rb);
        chk("rt_address", rt_address, e_rt);
        chk("I7", I7, e_imm % 128);
        chk("I10", I10, e_imm % 1024);
        chk("I16", I16, e_imm % 65536);
        chk("I18", I18, e_imm);
        chk("pc_output", pc_output, e_pc);
        if (issue_valid) iss_cyc[int'(op_op_code)] = cyc;
        stall_cnt += int'(stall);
        n_iss += int'(issue_valid);
    endtask

    task automatic send(input tinst_t i);
        bit acc;
        acc = 0;
        for (int n = 0; n < 40 && !acc; n++) step(1, i, 0, acc);
        chk("send_accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        tinst_t z;
        z = mk(LNOP, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) step(0, z, 0, acc);
    endtask

    initial begin
        bit acc;
        int base;
        tinst_t t;

        // Reset state.
        #2;
        chk("rst_op", op_op_code, LNOP);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ra", ra, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock);

        // Immediate slicing and pass-through.
        send(mk(ROTATE_QUADWORD_BY_BYTES_IMMEDIATE, 3, 0, 1, 0, 33, 18'h00007, 32'h1234_5678));
        idle(1);
        chk("imm_I7", I7, 7);
        chk("imm_I18", I18, 7);
        chk("imm_rt", rt_address, 33);
        chk("imm_pc", pc_output, 32'h1234_5678);
        idle(8);

        // Independent instructions go back to back.
        send(mk(SHIFT_LEFT_QUADWORD_BY_BITS, 1, 2, 1, 1, 5, 0, 32'h100));
        send(mk(ROTATE_QUADWORD_BY_BITS, 6, 7, 1, 1, 8, 0, 32'h104));
        idle(2);
        chk("b2b_gap", iss_cyc[int'(ROTATE_QUADWORD_BY_BITS)] - iss_cyc[int'(SHIFT_LEFT_QUADWORD_BY_BITS)], 1);
        idle(8);

        // RAW on a 4-cycle shift.
        stall_cnt = 0;
        base = n_iss;
        send(mk(SHIFT_LEFT_QUADWORD_BY_BITS, 1, 2, 1, 0, 5, 0, 32'h200));
        send(mk(GATHER_BITS_FROM_BYTES, 5, 3, 1, 0, 11, 0, 32'h204));
        idle(10);
        chk("raw_stall_cycles", stall_cnt, 4);
        chk("raw_gap", iss_cyc[int'(GATHER_BITS_FROM_BYTES)] - iss_cyc[int'(SHIFT_LEFT_QUADWORD_BY_BITS)], 5);
        chk("raw_issues", n_iss - base, 2);
        idle(4);

        // Fill the queue behind a load; full queue refuses, nothing lost.
        base = n_iss;
        send(mk(LOAD_QUADWORD_DFORM, 1, 2, 1, 0, 10, 0, 32'h300));
        for (int k = 0; k < 4; k++) send(mk(ROTATE_QUADWORD_BY_BYTES, 10, 2, 1, 0, 20 + k, 0, 32'h304 + 4 * k));
        t = mk(ROTATE_QUADWORD_BY_BYTES, 10, 2, 1, 0, 24, 0, 32'h314);
        step(1, t, 0, acc);
        chk("full_in_ready", last_rdy, 0);
        if (!acc) send(t);
        idle(14);
        chk("full_issues", n_iss - base, 6);

        // Flush: queued readers dropped, in-flight rt=9 still blocks until age 4.
        base = n_iss;
        send(mk(SHIFT_LEFT_QUADWORD_BY_BYTES, 1, 2, 1, 0, 9, 0, 32'h400));
        send(mk(ROTATE_QUADWORD_BY_BITS, 9, 2, 1, 0, 12, 0, 32'h404));
        send(mk(ROTATE_QUADWORD_BY_BITS, 9, 2, 1, 0, 13, 0, 32'h408));
        t = mk(GATHER_BITS_FROM_BYTES, 9, 2, 1, 0, 14, 0, 32'h40C);
        step(1, t, 1, acc);
        chk("flush_in_ready", last_rdy, 0);
        send(t);
        idle(10);
        chk("flush_gap", iss_cyc[int'(GATHER_BITS_FROM_BYTES)] - iss_cyc[int'(SHIFT_LEFT_QUADWORD_BY_BYTES)], 5);
        chk("flush_issues", n_iss - base, 2);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            t = mk(ops[$urandom_range(0, 11)], $urandom_range(0, 15), $urandom_range(0, 15),
                   1'($urandom), 1'($urandom), $urandom_range(0, 15), int'($urandom), int'($urandom));
            step($urandom_range(0, 3) != 0, t, $urandom_range(0, 24) == 0, acc);
        end
        idle(10);

        // Reset mid-stream with three instructions queued behind a load.
        send(mk(LOAD_QUADWORD_AFORM, 1, 2, 0, 0, 40, 0, 32'h500));
        for (int k = 0; k < 3; k++) send(mk(ROTATE_QUADWORD_BY_BITS, 40, 1, 1, 0, 41 + k, 0, 32'h504 + 4 * k));
        reset = 1'b0;
        #1;
        chk("midrst_op", op_op_code, LNOP);
        chk("midrst_issue_valid", issue_valid, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_pc", pc_output, 0);
        @(negedge clock);
        reset = 1'b1;
        mq.delete();
        inflight.delete();
        base = n_iss;
        idle(10);
        chk("midrst_no_issue", n_iss - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
